// File: rtl/npu_csr_pkg.sv
// Shared register offsets, bit indices, response codes and write-FSM states
// for the NPU control/status register bank.
package npu_csr_pkg;

    localparam logic [15:0] CtrlOff    = 16'h0000;
    localparam logic [15:0] StatusOff  = 16'h0004;
    localparam logic [15:0] IrqEnOff   = 16'h0008;
    localparam logic [15:0] SrcAddrOff = 16'h000C;
    localparam logic [15:0] DstAddrOff = 16'h0010;
    localparam logic [15:0] LenOff     = 16'h0014;
    localparam logic [15:0] IdOff      = 16'h0018;
    localparam logic [15:0] CyclesOff  = 16'h001C;

    localparam int CtrlStartBit  = 0;
    localparam int StatusBusyBit = 0;
    localparam int StatusDoneBit = 1;
    localparam int StatusErrBit  = 2;
    localparam int IrqEnDoneBit  = 0;
    localparam int IrqEnErrBit   = 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    // Byte offset of the 32-bit word selected by addr[15:2].
    function automatic logic [15:0] word_off(input logic [13:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/npu_csr_regs_if.sv
// 32-bit AXI-Lite bus without write strobes; m = host side, s = register bank.
interface axil_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport m (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/npu_csr_regs.sv
// AXI-Lite register bank for the NPU control/status window.
// Optional CYCLES busy counter at 0x1C when NPU_CSR_PERF_CNT_EN is defined.
module npu_csr_regs
    import npu_csr_pkg::*;
#(
    parameter logic [31:0] NPU_ID = 32'h4e50_0001,
    parameter int          LEN_W  = 24
) (
    input  logic             clk,
    input  logic             arst_n,
    axil_if.s                csr,
    output logic             npu_start,
    output logic [31:0]      npu_src_addr,
    output logic [31:0]      npu_dst_addr,
    output logic [LEN_W-1:0] npu_len,
    input  logic             npu_busy,
    input  logic             npu_done,
    input  logic             npu_err,
    output logic             irq
);

    wr_state_e   wr_state;
    logic [15:0] aw_off_q;
    logic [31:0] wdata_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        wr_commit;
    logic [15:0] wr_off;
    logic [31:0] wr_data;
    logic [15:0] rd_off;
    logic [31:0] rd_data;

    logic        done_q;
    logic        err_q;
    logic [1:0]  irq_en_q;

    logic        ctrl_start_wr;
    logic        start_ok;
    logic        start_busy;
    logic        status_wr;
    logic        done_next;
    logic        err_next;
    logic [1:0]  irq_en_next;

    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, csr.awaddr[31:16], csr.awaddr[1:0],
                                csr.araddr[31:16], csr.araddr[1:0]};

`ifdef NPU_CSR_PERF_CNT_EN
    logic [31:0] cycles_q;
`endif

    function automatic logic is_mapped(input logic [15:0] off);
        logic hit;
        hit = 1'b0;
        case (off)
            CtrlOff, StatusOff, IrqEnOff, SrcAddrOff,
            DstAddrOff, LenOff, IdOff: hit = 1'b1;
`ifdef NPU_CSR_PERF_CNT_EN
            CyclesOff:                 hit = 1'b1;
`endif
            default:                   hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign aw_hs = csr.awvalid & csr.awready;
    assign w_hs  = csr.wvalid & csr.wready;
    assign ar_hs = csr.arvalid & csr.arready;

    // A write commits on the edge where the second half (AW or W) arrives,
    // so the missing half is taken straight from the bus.
    assign wr_commit = ((wr_state == W_IDLE) && aw_hs && w_hs) ||
                       ((wr_state == W_HAVE_AW) && w_hs) ||
                       ((wr_state == W_HAVE_W) && aw_hs);
    assign wr_off  = (wr_state == W_HAVE_AW) ? aw_off_q : word_off(csr.awaddr[15:2]);
    assign wr_data = (wr_state == W_HAVE_W) ? wdata_q : csr.wdata;
    assign rd_off  = word_off(csr.araddr[15:2]);

    assign ctrl_start_wr = wr_commit && (wr_off == CtrlOff) && wr_data[CtrlStartBit];
    assign start_ok      = ctrl_start_wr && !npu_busy;
    assign start_busy    = ctrl_start_wr && npu_busy;
    assign status_wr     = wr_commit && (wr_off == StatusOff);

    // A set event wins over a simultaneous write-1-to-clear.
    assign done_next = (done_q & ~(status_wr & wr_data[StatusDoneBit])) | npu_done;
    assign err_next  = (err_q & ~(status_wr & wr_data[StatusErrBit])) | npu_err | start_busy;
    assign irq_en_next = (wr_commit && (wr_off == IrqEnOff)) ? wr_data[1:0] : irq_en_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state    <= W_IDLE;
            aw_off_q    <= '0;
            wdata_q     <= '0;
            csr.awready <= 1'b0;
            csr.wready  <= 1'b0;
            csr.bvalid  <= 1'b0;
            csr.bresp   <= OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state    <= W_RESP;
                        csr.awready <= 1'b0;
                        csr.wready  <= 1'b0;
                    end else if (aw_hs) begin
                        wr_state    <= W_HAVE_AW;
                        aw_off_q    <= word_off(csr.awaddr[15:2]);
                        csr.awready <= 1'b0;
                    end else if (w_hs) begin
                        wr_state    <= W_HAVE_W;
                        wdata_q     <= csr.wdata;
                        csr.wready  <= 1'b0;
                    end else begin
                        csr.awready <= 1'b1;
                        csr.wready  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        wr_state   <= W_RESP;
                        csr.wready <= 1'b0;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        wr_state    <= W_RESP;
                        csr.awready <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (csr.bready) begin
                        wr_state    <= W_IDLE;
                        csr.bvalid  <= 1'b0;
                        csr.awready <= 1'b1;
                        csr.wready  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
            if (wr_commit) begin
                csr.bvalid <= 1'b1;
                csr.bresp  <= is_mapped(wr_off) ? OKAY : SLVERR;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            StatusOff: begin
                rd_data[StatusBusyBit] = npu_busy;
                rd_data[StatusDoneBit] = done_q;
                rd_data[StatusErrBit]  = err_q;
            end
            IrqEnOff:   rd_data[1:0]       = irq_en_q;
            SrcAddrOff: rd_data            = npu_src_addr;
            DstAddrOff: rd_data            = npu_dst_addr;
            LenOff:     rd_data[LEN_W-1:0] = npu_len;
            IdOff:      rd_data            = NPU_ID;
`ifdef NPU_CSR_PERF_CNT_EN
            CyclesOff:  rd_data            = cycles_q;
`endif
            default:    rd_data            = '0;
        endcase
    end

    // Read data is captured on the AR edge, before any same-edge write lands.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            csr.arready <= 1'b0;
            csr.rvalid  <= 1'b0;
            csr.rdata   <= '0;
            csr.rresp   <= OKAY;
        end else if (ar_hs) begin
            csr.arready <= 1'b0;
            csr.rvalid  <= 1'b1;
            csr.rdata   <= rd_data;
            csr.rresp   <= is_mapped(rd_off) ? OKAY : SLVERR;
        end else if (csr.rvalid && csr.rready) begin
            csr.arready <= 1'b1;
            csr.rvalid  <= 1'b0;
        end else begin
            csr.arready <= !csr.rvalid;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            npu_src_addr <= '0;
            npu_dst_addr <= '0;
            npu_len      <= '0;
            irq_en_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            npu_start    <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (wr_commit && (wr_off == SrcAddrOff)) npu_src_addr <= wr_data;
            if (wr_commit && (wr_off == DstAddrOff)) npu_dst_addr <= wr_data;
            if (wr_commit && (wr_off == LenOff))     npu_len      <= wr_data[LEN_W-1:0];
            irq_en_q  <= irq_en_next;
            done_q    <= done_next;
            err_q     <= err_next;
            npu_start <= start_ok;
            irq       <= (done_next & irq_en_next[IrqEnDoneBit]) |
                         (err_next & irq_en_next[IrqEnErrBit]);
        end
    end

`ifdef NPU_CSR_PERF_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cycles_q <= '0;
        end else if (start_ok) begin
            cycles_q <= '0;
        end else if (npu_busy && (cycles_q != 32'hffff_ffff)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_npu_csr_regs.sv
// Directed self-checking bench for npu_csr_regs (covers NPU_CSR_PERF_CNT_EN
// either way).
module tb_npu_csr_regs;
    import npu_csr_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        npu_start;
    logic [31:0] npu_src_addr;
    logic [31:0] npu_dst_addr;
    logic [23:0] npu_len;
    logic        npu_busy;
    logic        npu_done;
    logic        npu_err;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    axil_if bus();

    npu_csr_regs dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .csr          (bus),
        .npu_start    (npu_start),
        .npu_src_addr (npu_src_addr),
        .npu_dst_addr (npu_dst_addr),
        .npu_len      (npu_len),
        .npu_busy     (npu_busy),
        .npu_done     (npu_done),
        .npu_err      (npu_err),
        .irq          (irq)
    );

    always @(posedge clk) if (npu_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // W follows AW by 'gap' cycles; B is held off for 'hold' cycles once valid.
    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input int gap,
                          input int hold, output logic [1:0] resp, output int lat);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0;
        w_done  = 0;
        n       = 0;
        resp    = 2'bxx;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        bus.wdata   = d;
        bus.wvalid  = (gap == 0);
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.wvalid  = 1'b0; end
            if (!w_done && !bus.wvalid && n >= gap) bus.wvalid = 1'b1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        lat = 1;
        while (bus.bvalid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (bus.bvalid === 1'b1) begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_bvalid", {31'b0, bus.bvalid}, 32'd1);
                chk("hold_awready", {31'b0, bus.awready}, 32'd0);
                tick();
            end
            resp = bus.bresp;
            bus.bready = 1'b1;
            tick();
            bus.bready = 1'b0;
        end
    endtask

    task automatic axi_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
        int g;
        g = 0;
        d = 'x;
        resp = 2'bxx;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (bus.arready !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        tick();
        bus.arvalid = 1'b0;
        lat = 1;
        while (bus.rvalid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (bus.rvalid === 1'b1) begin
            d = bus.rdata;
            resp = bus.rresp;
            bus.rready = 1'b1;
            tick();
            bus.rready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        int          lat;
        int          s0;

        arst_n = 1'b0;
        npu_busy = 1'b0;
        npu_done = 1'b0;
        npu_err  = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_awready", {31'b0, bus.awready}, 32'd0);
        chk("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_start", {31'b0, npu_start}, 32'd0);
        chk("rst_src", npu_src_addr, 32'd0);
        arst_n = 1'b1;
        #1;
        chk("post_rst_awready_low", {31'b0, bus.awready}, 32'd0);
        tick();
        chk("post_rst_awready", {31'b0, bus.awready}, 32'd1);
        chk("post_rst_wready", {31'b0, bus.wready}, 32'd1);
        chk("post_rst_arready", {31'b0, bus.arready}, 32'd1);

        // ID and reset value of SRC_ADDR
        axi_rd(32'hc000_0018, d, resp, lat);
        chk("id_data", d, 32'h4e50_0001);
        chk("id_resp", {30'b0, resp}, {30'b0, OKAY});
        chk("rd_latency", lat, 32'd1);
        axi_rd(32'hc000_000c, d, resp, lat);
        chk("src_rst_rd", d, 32'd0);

        // SRC_ADDR with AW two cycles ahead of W
        axi_wr(32'hc000_000c, 32'hdead_beef, 2, 0, resp, lat);
        chk("src_wr_lat", lat, 32'd1);
        chk("src_wr_resp", {30'b0, resp}, {30'b0, OKAY});
        chk("src_out", npu_src_addr, 32'hdead_beef);
        axi_rd(32'hc000_000c, d, resp, lat);
        chk("src_rd", d, 32'hdead_beef);

        // DST_ADDR and LEN width truncation
        axi_wr(32'hc000_0010, 32'h1234_5678, 0, 0, resp, lat);
        chk("dst_wr_lat", lat, 32'd1);
        chk("dst_out", npu_dst_addr, 32'h1234_5678);
        axi_wr(32'hc000_0014, 32'hffff_ffff, 0, 0, resp, lat);
        chk("len_out", {8'b0, npu_len}, 32'h00ff_ffff);
        axi_rd(32'hc000_0014, d, resp, lat);
        chk("len_rd", d, 32'h00ff_ffff);

        // START while idle: exactly one pulse, CTRL reads 0
        s0 = start_cnt;
        axi_wr(32'hc000_0000, 32'h1, 0, 0, resp, lat);
        repeat (3) tick();
        chk("start_pulses", start_cnt - s0, 32'd1);
        axi_rd(32'hc000_0000, d, resp, lat);
        chk("ctrl_rd", d, 32'd0);

        // START while busy: no pulse, ERR set
        npu_busy = 1'b1;
        s0 = start_cnt;
        axi_wr(32'hc000_0000, 32'h1, 0, 0, resp, lat);
        repeat (3) tick();
        chk("start_busy_pulses", start_cnt - s0, 32'd0);
        axi_rd(32'hc000_0004, d, resp, lat);
        chk("status_busy_err", d, 32'h5);
        npu_busy = 1'b0;
        axi_wr(32'hc000_0004, 32'h4, 0, 0, resp, lat);
        axi_rd(32'hc000_0004, d, resp, lat);
        chk("status_err_clr", d, 32'h0);

        // DONE interrupt
        axi_wr(32'hc000_0008, 32'h1, 0, 0, resp, lat);
        axi_rd(32'hc000_0008, d, resp, lat);
        chk("irq_en_rd", d, 32'h1);
        chk("irq_idle", {31'b0, irq}, 32'd0);
        npu_done = 1'b1;
        tick();
        npu_done = 1'b0;
        chk("irq_done", {31'b0, irq}, 32'd1);

        // W1C of DONE colliding with a new npu_done pulse
        bus.awaddr = 32'hc000_0004; bus.awvalid = 1'b1;
        bus.wdata  = 32'h2;         bus.wvalid  = 1'b1;
        npu_done = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; npu_done = 1'b0;
        chk("collide_bvalid", {31'b0, bus.bvalid}, 32'd1);
        chk("collide_bresp", {30'b0, bus.bresp}, {30'b0, OKAY});
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        axi_rd(32'hc000_0004, d, resp, lat);
        chk("collide_status", d, 32'h2);
        chk("collide_irq", {31'b0, irq}, 32'd1);

        // Plain W1C drops irq
        axi_wr(32'hc000_0004, 32'h2, 0, 0, resp, lat);
        chk("w1c_irq", {31'b0, irq}, 32'd0);
        axi_rd(32'hc000_0004, d, resp, lat);
        chk("w1c_status", d, 32'h0);

        // ERR interrupt path
        axi_wr(32'hc000_0008, 32'h2, 0, 0, resp, lat);
        npu_err = 1'b1;
        tick();
        npu_err = 1'b0;
        chk("irq_err", {31'b0, irq}, 32'd1);
        axi_wr(32'hc000_0004, 32'h4, 0, 0, resp, lat);
        chk("irq_err_clr", {31'b0, irq}, 32'd0);

        // Write to read-only ID
        axi_wr(32'hc000_0018, 32'h0, 0, 0, resp, lat);
        chk("ro_wr_resp", {30'b0, resp}, {30'b0, OKAY});
        axi_rd(32'hc000_0018, d, resp, lat);
        chk("ro_id_kept", d, 32'h4e50_0001);

        // Unmapped offset with B held off
        axi_wr(32'hc000_2000, 32'hffff_ffff, 0, 5, resp, lat);
        chk("unmap_wr_resp", {30'b0, resp}, {30'b0, SLVERR});
        axi_rd(32'hc000_2000, d, resp, lat);
        chk("unmap_rd_resp", {30'b0, resp}, {30'b0, SLVERR});
        chk("unmap_rd_data", d, 32'd0);
        chk("unmap_src_kept", npu_src_addr, 32'hdead_beef);

`ifdef NPU_CSR_PERF_CNT_EN
        // CYCLES: cleared by start, counts 10 busy cycles
        axi_wr(32'hc000_0000, 32'h1, 0, 0, resp, lat);
        npu_busy = 1'b1;
        repeat (10) tick();
        npu_busy = 1'b0;
        axi_rd(32'hc000_001c, d, resp, lat);
        chk("cycles_resp", {30'b0, resp}, {30'b0, OKAY});
        chk("cycles_val", d, 32'd10);
`else
        axi_rd(32'hc000_001c, d, resp, lat);
        chk("cycles_unmap_resp", {30'b0, resp}, {30'b0, SLVERR});
        chk("cycles_unmap_data", d, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/npu_csr_regs.md
Name: npu_csr_regs

Overview:
- AXI-Lite slave register bank for the NPU control/status window.
- Sits directly downstream of the host MMIO interconnect and terminates its npu_csr master port.
- The interconnect forwards only the 0xc000_0000/0xffff_0000 window, so decoding uses addr[15:0].
- Drives start/configuration to the NPU core, collects busy/done/error, and raises a level interrupt to the host.

Parameters:
- NPU_ID, 32'h4e50_0001, constant value returned by the ID register.
- LEN_W, 24, implemented width of LEN; upper bits read 0.

Ports:
- clk  in  1  single clock.
- arst_n  in  1  reset; asynchronous assert, active-low.
- csr  axil_if.s  -  32-bit AXI-Lite slave. No wstrb: every write is full-word. bresp/rresp are driven by this block.
- npu_start  out  1  one-cycle start pulse.
- npu_src_addr  out  32  SRC_ADDR register value.
- npu_dst_addr  out  32  DST_ADDR register value.
- npu_len  out  LEN_W  LEN register value.
- npu_busy  in  1  core busy level.
- npu_done  in  1  one-cycle completion pulse.
- npu_err  in  1  one-cycle error pulse.
- irq  out  1  registered level interrupt.

Behaviour:
- Reset: all registers 0; awready/wready/arready 0 for one cycle, then 1; bvalid/rvalid 0; npu_start 0; irq 0.
- Register map (offset addr[15:0]; addr[1:0] ignored):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0).
  - 0x04 STATUS: bit0 BUSY (RO, = npu_busy), bit1 DONE (sticky, W1C), bit2 ERR (sticky, W1C).
  - 0x08 IRQ_EN: bits[1:0] RW.
  - 0x0C SRC_ADDR: RW.
  - 0x10 DST_ADDR: RW.
  - 0x14 LEN: RW, LEN_W bits.
  - 0x18 ID: RO, NPU_ID.
- Responses: any other offset returns SLVERR, read data 0, write ignored. Writes to RO registers return OKAY and are ignored.
- Write channel:
  - AW and W are accepted independently; each is latched in a holding register.
  - awready deasserts after an AW is captured until its B handshake; wready behaves the same for W.
  - The register update occurs in the cycle after both AW and W are held. bvalid rises in that same cycle.
  - bvalid holds until bready. The next AW/W may be accepted in the cycle after the B handshake.
  - AW and W in the same cycle: bvalid in cycle +1.
- Write FSM: W_IDLE → W_HAVE_AW / W_HAVE_W → W_RESP → W_IDLE.
- Read channel:
  - arready = !rvalid. rdata is registered and rvalid rises the cycle after the AR handshake.
  - rvalid/rdata hold until rready. Single outstanding read.
  - Read and write to the same register in the same cycle: the read returns the pre-write value.
- START:
  - Writing START=1 with npu_busy=0 gives npu_start=1 for exactly one cycle (cycle after the write commits).
  - Writing START=1 with npu_busy=1 gives no pulse and sets ERR.
- Sticky bits: npu_done sets DONE and npu_err sets ERR. A set event in the same cycle as a W1C of that bit leaves the bit set.
- irq: registered, = (DONE & IRQ_EN[0]) | (ERR & IRQ_EN[1]).
- Reset mid-transaction: all channels abort; no response is issued.

Optional Feature:
- Macro NPU_CSR_PERF_CNT_EN.
- Defined: adds a 32-bit register CYCLES at 0x1C (RO).
  - Clears to 0 on an accepted start pulse.
  - Increments each cycle while npu_busy=1.
  - Saturates at 32'hffff_ffff.
- Undefined: 0x1C is unmapped (SLVERR), and the counter logic is absent.

Decomposition:
- Package npu_csr_pkg holds:
  - offset localparams (CtrlOff…IdOff, CyclesOff);
  - STATUS/CTRL/IRQ_EN bit-index constants;
  - the write-FSM state enum;
  - the response codes OKAY=2'b00 and SLVERR=2'b10.
- No sub-module: a single flat module is natural.

Test Plan:
- Reset, then read 0x18 → rdata=32'h4e50_0001, rresp=OKAY. Read 0x0C → 0.
- Write 0x0C=32'hdead_beef with AW two cycles before W → bvalid one cycle after W accepted, OKAY; npu_src_addr=32'hdead_beef; readback matches.
- Write 0x00=1 with npu_busy=0 → single-cycle npu_start. Repeat with npu_busy=1 → no pulse, STATUS reads 32'h5.
- IRQ_EN=1, pulse npu_done → irq=1 next cycle. Write STATUS=2 in the same cycle as another npu_done → DONE stays 1. Write STATUS=2 alone → irq=0 in the following cycle.
- Read and write 0x2000 → SLVERR, rdata=0. Hold bready=0 for 5 cycles → bvalid stable and awready=0 throughout.
- With NPU_CSR_PERF_CNT_EN: start, hold npu_busy for 10 cycles → CYCLES=10. Without the macro: read 0x1C → SLVERR.
